bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: max consecutive granted cycles for an owner while the other master requests (legal 2..255).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports m0_req, m1_req  input  1 each  master requests bus.
REQ-005 SHALL have ports m0_gnt, m1_gnt  output  1 each  registered grant; at most one high.
REQ-006 SHALL have ports mN_read_addr, mN_write_addr, mN_write_data (N=0,1)  input  16 each  master bus drive.
REQ-007 SHALL have ports mN_write_strobe (N=0,1)  input  1  master write request.
REQ-008 SHALL have ports mN_read_data (N=0,1)  output  16  returned read data.
REQ-009 SHALL have ports mN_read_valid (N=0,1)  output  1  mN_read_data valid this cycle.
REQ-010 SHALL have ports bus_read_addr, bus_write_addr, bus_write_data  output  16 each  shared bus drive.
REQ-011 SHALL have port bus_write_strobe  output  1  shared write strobe.
REQ-012 SHALL have port bus_read_data  input  16  shared read data, valid one cycle after bus_read_addr.

Function
REQ-013 SHALL implement states IDLE, OWN0, OWN1; m0_gnt=1 only in OWN0, m1_gnt=1 only in OWN1.
REQ-014 SHALL, in IDLE, move to OWN0/OWN1 at the next edge for a sole requester; both requesting -> master not most recently granted wins.
REQ-015 SHALL, in OWNn, stay while mn_req=1 and hold limit not reached.
REQ-016 SHALL, in OWNn with mn_req=0 at an edge: other requesting -> direct handover to other owner (no gap cycle), else -> IDLE.
REQ-017 SHALL keep hold counter: clears on entry to any state; increments each OWNn cycle other master requests; holds when other idle.
REQ-018 SHALL, when counter == MAX_HOLD-1 and other master requests at an edge, hand over to other master regardless of mn_req.
REQ-019 SHALL drive bus_read_addr/bus_write_addr/bus_write_data combinationally from granted master; all zero in IDLE.
REQ-020 SHALL drive bus_write_strobe = mn_write_strobe AND mn_gnt; strobes from non-granted master dropped, never queued.
REQ-021 SHALL register previous-cycle owner (none/0/1); mN_read_valid=1 for exactly one cycle when previous owner was N.
REQ-022 SHALL route bus_read_data to both mN_read_data unconditionally; validity qualified only by mN_read_valid.
REQ-023 SHALL, at handover, give read data for the last old-owner cycle to old owner (valid on old master the cycle new owner starts).
REQ-024 SHALL grant latency: req high sampled at edge k from IDLE -> gnt high after edge k; no combinational req->gnt path.
REQ-025 SHALL track last-granted master, updated on every entry to OWN0/OWN1.

Reset
REQ-026 SHALL, on i_rst=1 at an edge (including mid-ownership): state IDLE, both gnt 0, counter 0, previous owner none, last-granted = M1 (M0 wins first tie).
REQ-027 SHALL, while in reset and cycle after, hold bus_write_strobe=0, all mN_read_valid=0, bus addr/data outputs 0.

Verification
REQ-028 SHALL test: reset, both req=1 same edge -> m0_gnt=1 next cycle; m0 drops req -> m1_gnt=1 next cycle, no IDLE cycle.
REQ-029 SHALL test: MAX_HOLD=4, m0 owns, m1 req continuously -> m0_gnt low after exactly 4 contended cycles, m1_gnt high same edge.
REQ-030 SHALL test: m1 owns, m0 writes 16'hBEEF at 16'h8100 with strobe -> bus_write_strobe stays 0; m1 write 16'h1234 to 16'h0010 appears on bus same cycle.
REQ-031 SHALL test: m0 reads 16'h0020 in last owned cycle, handover to m1 -> next cycle m0_read_valid=1 with RAM data, m1_read_valid=0.
REQ-032 SHALL test: i_rst asserted mid-OWN1 with strobe high -> next cycle m1_gnt=0, bus_write_strobe=0, both read_valid=0; post-reset tie -> M0 wins.
REQ-033 SHALL test: single requester m1, m0 idle 100 cycles -> m1_gnt never drops, counter never triggers handover.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between two bus masters, the arbiter and the shared bus.
// The arbiter sits on the slave modport; masters and memory use the master modport.
interface bus_arbiter_if;
  localparam int unsigned DW = 16;

  logic          m0_req;
  logic          m1_req;
  logic          m0_gnt;
  logic          m1_gnt;

  logic [DW-1:0] m0_read_addr;
  logic [DW-1:0] m0_write_addr;
  logic [DW-1:0] m0_write_data;
  logic          m0_write_strobe;
  logic [DW-1:0] m0_read_data;
  logic          m0_read_valid;

  logic [DW-1:0] m1_read_addr;
  logic [DW-1:0] m1_write_addr;
  logic [DW-1:0] m1_write_data;
  logic          m1_write_strobe;
  logic [DW-1:0] m1_read_data;
  logic          m1_read_valid;

  logic [DW-1:0] bus_read_addr;
  logic [DW-1:0] bus_write_addr;
  logic [DW-1:0] bus_write_data;
  logic          bus_write_strobe;
  logic [DW-1:0] bus_read_data;

  modport slave (
    input  m0_req, m1_req,
    input  m0_read_addr, m0_write_addr, m0_write_data, m0_write_strobe,
    input  m1_read_addr, m1_write_addr, m1_write_data, m1_write_strobe,
    input  bus_read_data,
    output m0_gnt, m1_gnt,
    output m0_read_data, m0_read_valid, m1_read_data, m1_read_valid,
    output bus_read_addr, bus_write_addr, bus_write_data, bus_write_strobe
  );

  modport master (
    output m0_req, m1_req,
    output m0_read_addr, m0_write_addr, m0_write_data, m0_write_strobe,
    output m1_read_addr, m1_write_addr, m1_write_data, m1_write_strobe,
    output bus_read_data,
    input  m0_gnt, m1_gnt,
    input  m0_read_data, m0_read_valid, m1_read_data, m1_read_valid,
    input  bus_read_addr, bus_write_addr, bus_write_data, bus_write_strobe
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter: fair tie-break, bounded hold under contention,
// zero-gap handover, and read-valid steering to the owner of the previous cycle.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bus_arbiter_if.slave  io
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PREV_NONE = 2'd0,
    PREV_M0   = 2'd1,
    PREV_M1   = 2'd2
  } prev_e;

  state_e        state_q, state_d;
  prev_e         prev_q, prev_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          last_q, last_d;   // 1: M1 was granted most recently
  logic          hold_at_max;
  logic          contended;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      prev_q  <= PREV_NONE;
      hold_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign hold_at_max = (hold_q == CW'(MAX_HOLD - 1));

  // Next-state, hold counter, last-granted and previous-owner tracking.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    prev_d    = PREV_NONE;
    contended = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.m0_req && io.m1_req) state_d = last_q ? OWN0 : OWN1;
        else if (io.m0_req)         state_d = OWN0;
        else if (io.m1_req)         state_d = OWN1;
      end
      OWN0: begin
        contended = io.m1_req;
        prev_d    = PREV_M0;
        if (io.m1_req && hold_at_max) state_d = OWN1;
        else if (!io.m0_req)          state_d = io.m1_req ? OWN1 : IDLE;
      end
      OWN1: begin
        contended = io.m0_req;
        prev_d    = PREV_M1;
        if (io.m0_req && hold_at_max) state_d = OWN0;
        else if (!io.m1_req)          state_d = io.m0_req ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
    end else if (contended) begin
      hold_d = hold_q + CW'(1);
    end
  end

  assign io.m0_gnt = (state_q == OWN0);
  assign io.m1_gnt = (state_q == OWN1);

  // Shared bus mux; forced quiet while reset is asserted.
  always_comb begin
    io.bus_read_addr    = '0;
    io.bus_write_addr   = '0;
    io.bus_write_data   = '0;
    io.bus_write_strobe = 1'b0;
    if (!i_rst) begin
      case (state_q)
        OWN0: begin
          io.bus_read_addr    = io.m0_read_addr;
          io.bus_write_addr   = io.m0_write_addr;
          io.bus_write_data   = io.m0_write_data;
          io.bus_write_strobe = io.m0_write_strobe;
        end
        OWN1: begin
          io.bus_read_addr    = io.m1_read_addr;
          io.bus_write_addr   = io.m1_write_addr;
          io.bus_write_data   = io.m1_write_data;
          io.bus_write_strobe = io.m1_write_strobe;
        end
        default: ;
      endcase
    end
  end

  // Read data lags the address by one cycle, so validity follows last cycle's owner.
  assign io.m0_read_data  = io.bus_read_data;
  assign io.m1_read_data  = io.bus_read_data;
  assign io.m0_read_valid = !i_rst && (prev_q == PREV_M0);
  assign io.m1_read_valid = !i_rst && (prev_q == PREV_M1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle expectations are queued with the stimulus
// and popped/compared mid-cycle; a small memory model returns registered read data.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bus_arbiter_if ifc ();

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (ifc)
  );

  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  // Memory returns data one cycle after the address.
  initial ifc.bus_read_data = '0;
  always @(posedge clk) ifc.bus_read_data <= ram_f(ifc.bus_read_addr);

  typedef struct {
    string       tag;
    logic        g0, g1, ws, rv0, rv1;
    logic        chk_bus;
    logic [15:0] wa, wd, ra;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];

  task automatic push_full(input string tag, input logic g0, input logic g1, input logic ws,
                           input logic rv0, input logic rv1, input logic chk_bus,
                           input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra,
                           input logic chk_rd, input logic [15:0] rd);
    exp_t e;
    e.tag = tag; e.g0 = g0; e.g1 = g1; e.ws = ws; e.rv0 = rv0; e.rv1 = rv1;
    e.chk_bus = chk_bus; e.wa = wa; e.wd = wd; e.ra = ra;
    e.chk_rd = chk_rd; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic push(input string tag, input logic g0, input logic g1, input logic ws,
                      input logic rv0, input logic rv1);
    push_full(tag, g0, g1, ws, rv0, rv1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk1(input string tag, input string nm, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s %s observed %b expected %b", tag, nm, obs, exp);
  endtask

  task automatic chk16(input string tag, input string nm, input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s %s observed %h expected %h", tag, nm, obs, exp);
  endtask

  // Compare queued expectations against this cycle's outputs, then move to the next cycle.
  task automatic cyc();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk1(e.tag, "m0_gnt", ifc.m0_gnt, e.g0);
      chk1(e.tag, "m1_gnt", ifc.m1_gnt, e.g1);
      chk1(e.tag, "bus_write_strobe", ifc.bus_write_strobe, e.ws);
      chk1(e.tag, "m0_read_valid", ifc.m0_read_valid, e.rv0);
      chk1(e.tag, "m1_read_valid", ifc.m1_read_valid, e.rv1);
      if (e.chk_bus) begin
        chk16(e.tag, "bus_write_addr", ifc.bus_write_addr, e.wa);
        chk16(e.tag, "bus_write_data", ifc.bus_write_data, e.wd);
        chk16(e.tag, "bus_read_addr", ifc.bus_read_addr, e.ra);
      end
      if (e.chk_rd) begin
        chk16(e.tag, "m0_read_data", ifc.m0_read_data, e.rd);
        chk16(e.tag, "m1_read_data", ifc.m1_read_data, e.rd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    ifc.m0_read_addr = '0; ifc.m0_write_addr = '0; ifc.m0_write_data = '0;
    ifc.m1_read_addr = '0; ifc.m1_write_addr = '0; ifc.m1_write_data = '0;
    ifc.m0_write_strobe = 1'b0; ifc.m1_write_strobe = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then a tie: M0 wins, and drops req for a gapless handover to M1.
    push_full("reset", 0, 0, 0, 0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, '0);
    cyc();
    rst = 1'b0; ifc.m0_req = 1'b1; ifc.m1_req = 1'b1;
    push("post_reset_idle", 0, 0, 0, 0, 0);
    cyc();
    push("tie_m0_wins", 1, 0, 0, 0, 0);
    cyc();
    ifc.m0_req = 1'b0;
    push("m0_last_cycle", 1, 0, 0, 1, 0);
    cyc();
    push("handover_no_gap", 0, 1, 0, 1, 0);
    cyc();
    ifc.m1_req = 1'b0;
    push("m1_release", 0, 1, 0, 0, 1);
    cyc();
    push("idle_after_m1", 0, 0, 0, 0, 1);
    cyc();
    ifc.m0_req = 1'b1;
    push("idle_sole_m0", 0, 0, 0, 0, 0);
    cyc();

    // Hold limit of 4 while M1 requests continuously.
    ifc.m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("hold_m0_owns", 1, 0, 0, (i > 0), 0);
      cyc();
    end
    push("hold_limit_handover", 0, 1, 0, 1, 0);
    cyc();

    // Non-owner strobe is dropped; owner write reaches the bus the same cycle.
    ifc.m0_req = 1'b0;
    ifc.m0_write_strobe = 1'b1; ifc.m0_write_addr = 16'h8100; ifc.m0_write_data = 16'hBEEF;
    ifc.m1_write_strobe = 1'b1; ifc.m1_write_addr = 16'h0010; ifc.m1_write_data = 16'h1234;
    push_full("m1_write", 0, 1, 1, 0, 1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, '0);
    cyc();
    ifc.m1_write_strobe = 1'b0; ifc.m1_write_addr = 16'h0044; ifc.m1_write_data = 16'h0000;
    push_full("m0_strobe_dropped", 0, 1, 0, 0, 1, 1'b1, 16'h0044, 16'h0000, 16'h0000, 1'b0, '0);
    cyc();

    // M0 reads in its last owned cycle; data goes back to M0 while M1 owns.
    ifc.m0_write_strobe = 1'b0;
    ifc.m1_req = 1'b0; ifc.m0_req = 1'b1;
    push("m1_to_m0", 0, 1, 0, 0, 1);
    cyc();
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b1; ifc.m0_read_addr = 16'h0020;
    push_full("m0_read_last", 1, 0, 0, 0, 1, 1'b1, 16'h8100, 16'hBEEF, 16'h0020, 1'b0, '0);
    cyc();
    push_full("read_to_old_owner", 0, 1, 0, 1, 0, 1'b0, '0, '0, '0, 1'b1, ram_f(16'h0020));
    cyc();

    // Reset in the middle of M1 ownership with a strobe pending.
    rst = 1'b1; ifc.m1_write_strobe = 1'b1; ifc.m1_write_addr = 16'h0055;
    push_full("reset_mid_own1", 0, 1, 0, 0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, '0);
    cyc();
    rst = 1'b0; ifc.m0_req = 1'b1;
    push_full("after_reset", 0, 0, 0, 0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, '0);
    cyc();
    ifc.m1_write_strobe = 1'b0; ifc.m0_req = 1'b0;
    push("post_reset_tie_m0", 1, 0, 0, 0, 0);
    cyc();

    // Sole requester M1 for 100 cycles: no forced handover.
    for (int i = 0; i < 100; i++) begin
      push("solo_m1", 0, 1, 0, (i == 0), (i > 0));
      cyc();
    end
    ifc.m1_req = 1'b0;
    push("solo_m1_release", 0, 1, 0, 0, 1);
    cyc();
    push("final_idle", 0, 0, 0, 0, 1);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
